seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display that shows the score. It is sequenced by the ~762.9 Hz one-cycle segment strobe from the display clock divider and drives one digit at a time. Each digit switch is separated by a programmable all-off blanking gap to suppress ghosting. The displayed value is latched once per frame, so the display never shows a mix of old and new digits.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seg7_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Contents: scan state enum, dark-output constants, hex-to-segment table
// (active-low, bit order {g,f,e,d,c,b,a}).
package seg7_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned VAL_W  = DIGITS * NIB_W;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [SEG_W-1:0]  SEG_OFF = 7'h7F;
  localparam logic [DIGITS-1:0] AN_OFF  = 4'hF;

  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Ports: i_hex  - 4-bit hex digit
//        o_seg_c - segments {g,f,e,d,c,b,a}, active-low
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] i_hex,
  output logic [SEG_W-1:0] o_seg_c
);

  assign o_seg_c = HEX_SEG[i_hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode display scanner with per-switch blanking gap and
// once-per-frame latching of the displayed value.
// Ports: clk, clr (sync active-high reset), tick (digit-advance strobe),
//        enable, value[15:0], dp_in[3:0], lzb_en  -> an[3:0], seg[6:0], dp,
//        frame_start. All outputs are registered; an/seg/dp are active-low.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned BLANK_CYC = 256
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              tick,
  input  logic              enable,
  input  logic [VAL_W-1:0]  value,
  input  logic [DIGITS-1:0] dp_in,
  input  logic              lzb_en,
  output logic [DIGITS-1:0] an,
  output logic [SEG_W-1:0]  seg,
  output logic              dp,
  output logic              frame_start
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYC - 1);

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [VAL_W-1:0]    r_sh_value, w_sh_value_nxt;
  logic [DIGITS-1:0]   r_sh_dp, w_sh_dp_nxt;
  logic                r_sh_lzb, w_sh_lzb_nxt;
  logic [DIGITS-1:0]   r_an, w_an_nxt;
  logic [SEG_W-1:0]    r_seg, w_seg_nxt;
  logic                r_dp, w_dp_nxt;
  logic                r_fs, w_fs_nxt;

  logic [NIB_W-1:0]    w_nib;
  logic [SEG_W-1:0]    w_seg_dec;
  logic                w_lead_zero;
  logic [DIGITS-1:0]   w_an_dig;
  logic [SEG_W-1:0]    w_seg_dig;
  logic                w_dp_dig;

  // Current digit's nibble and its drive pattern from the frame shadows.
  assign w_nib = NIB_W'(r_sh_value >> {r_idx, 2'b00});

  seg7_hex_decode u_dec (
    .i_hex   (w_nib),
    .o_seg_c (w_seg_dec)
  );

  // Shifting right by idx nibbles leaves nibbles idx..3; all zero means leading.
  assign w_lead_zero = r_sh_lzb && (r_idx != IDX_W'(0)) &&
                       ((r_sh_value >> {r_idx, 2'b00}) == VAL_W'(0));
  assign w_an_dig    = ~(DIGITS'(1) << r_idx);
  assign w_seg_dig   = w_lead_zero ? SEG_OFF : w_seg_dec;
  assign w_dp_dig    = ~r_sh_dp[r_idx];

  // Next-state and next-output logic; outputs default to dark.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_sh_value_nxt = r_sh_value;
    w_sh_dp_nxt    = r_sh_dp;
    w_sh_lzb_nxt   = r_sh_lzb;
    w_an_nxt       = AN_OFF;
    w_seg_nxt      = SEG_OFF;
    w_dp_nxt       = 1'b1;
    w_fs_nxt       = 1'b0;

    if (!enable) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = IDX_W'(0);
      w_cnt_nxt   = CNT_W'(0);
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt    = BLANK;
          w_idx_nxt      = IDX_W'(0);
          w_cnt_nxt      = CNT_W'(0);
          w_sh_value_nxt = value;
          w_sh_dp_nxt    = dp_in;
          w_sh_lzb_nxt   = lzb_en;
        end
        BLANK: begin
          // tick is deliberately ignored here
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = SHOW;
            w_an_nxt    = w_an_dig;
            w_seg_nxt   = w_seg_dig;
            w_dp_nxt    = w_dp_dig;
            w_fs_nxt    = (r_idx == IDX_W'(0));
          end
        end
        SHOW: begin
          if (tick) begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = CNT_W'(0);
            w_idx_nxt   = r_idx + IDX_W'(1);
            // Wrapping to digit 0 starts a new frame: latch the inputs now.
            if (r_idx == IDX_W'(DIGITS - 1)) begin
              w_sh_value_nxt = value;
              w_sh_dp_nxt    = dp_in;
              w_sh_lzb_nxt   = lzb_en;
            end
          end else begin
            w_an_nxt  = w_an_dig;
            w_seg_nxt = w_seg_dig;
            w_dp_nxt  = w_dp_dig;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= IDLE;
      r_idx      <= IDX_W'(0);
      r_cnt      <= CNT_W'(0);
      r_sh_value <= VAL_W'(0);
      r_sh_dp    <= DIGITS'(0);
      r_sh_lzb   <= 1'b0;
      r_an       <= AN_OFF;
      r_seg      <= SEG_OFF;
      r_dp       <= 1'b1;
      r_fs       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sh_value <= w_sh_value_nxt;
      r_sh_dp    <= w_sh_dp_nxt;
      r_sh_lzb   <= w_sh_lzb_nxt;
      r_an       <= w_an_nxt;
      r_seg      <= w_seg_nxt;
      r_dp       <= w_dp_nxt;
      r_fs       <= w_fs_nxt;
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus randomized traffic, every
// cycle compared against a digit-level behavioural model.
module tb_seg7_scan_ctrl;

  localparam int B = 4;

  logic        clk;
  logic        clr;
  logic        tick;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lzb_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  seg7_scan_ctrl #(.BLANK_CYC(B)) dut (
    .clk         (clk),
    .clr         (clr),
    .tick        (tick),
    .enable      (enable),
    .value       (value),
    .dp_in       (dp_in),
    .lzb_en      (lzb_en),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit chk_on  = 0;
  int tick_mode = 0;   // 0 none, 1 periodic, 2 random
  int tick_per  = 20;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Model: digit position, whether lit, dark cycles remaining, frame snapshot.
  bit m_idle = 1;
  bit m_show = 0;
  int m_d    = 0;
  int m_left = 0;
  int m_val  = 0;
  int m_dpm  = 0;
  int m_lzb  = 0;
  int m_fs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic snap();
    m_val = int'(value);
    m_dpm = int'(dp_in);
    m_lzb = int'(lzb_en);
  endtask

  task automatic model_step();
    m_fs = 0;
    if (clr) begin
      m_idle = 1; m_show = 0; m_d = 0;
      m_val = 0; m_dpm = 0; m_lzb = 0;
    end else if (!enable) begin
      m_idle = 1; m_show = 0;
    end else if (m_idle) begin
      m_idle = 0; m_show = 0; m_left = B; m_d = 0;
      snap();
    end else if (!m_show) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_show = 1;
        m_fs = (m_d == 0) ? 1 : 0;
      end
    end else if (tick) begin
      m_show = 0; m_left = B;
      m_d = (m_d + 1) % 4;
      if (m_d == 0) snap();
    end
  endtask

  task automatic cycle_check();
    int upper;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    ea = 4'hF; es = 7'h7F; ed = 1'b1;
    if (m_show) begin
      upper = m_val >> (4 * m_d);
      ea = 4'(15 - (1 << m_d));
      es = (m_lzb != 0 && m_d != 0 && upper == 0) ? 7'h7F : seg_tab[upper % 16];
      ed = (((m_dpm >> m_d) & 1) != 0) ? 1'b0 : 1'b1;
    end
    check("an",  32'(an),  32'(ea));
    check("seg", 32'(seg), 32'(es));
    check("dp",  32'(dp),  32'(ed));
    check("frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  // Wait (bounded) until an shows target; returns dark samples and cycles waited.
  task automatic wait_an(input logic [3:0] target, output int dark, output int cyc);
    dark = 0; cyc = 0;
    while (an !== target && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (an === 4'hF) dark++;
    end
    if (an !== target) check("wait_timeout", 32'(an), 32'(target));
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) cycle_check();
  end

  initial begin
    int tcnt;
    tick = 0; tcnt = 0;
    forever begin
      @(negedge clk);
      tcnt++;
      case (tick_mode)
        1:       tick = (tcnt % tick_per == 0);
        2:       tick = ($urandom_range(0, 7) == 0);
        default: tick = 0;
      endcase
    end
  end

  initial begin
    int dk, cy;
    clr = 1; enable = 0; value = 16'h0; dp_in = 4'h0; lzb_en = 0;
    repeat (2) @(negedge clk);
    chk_on = 1;
    check("rst_an",  32'(an),  32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp",  32'(dp),  32'h1);
    check("rst_fs",  32'(frame_start), 32'h0);

    // Basic scan of 1234
    clr = 0; value = 16'h1234; enable = 1; tick_per = 20; tick_mode = 1;
    wait_an(4'hE, dk, cy);
    check("b_seg0", 32'(seg), 32'h19);
    check("b_fs0",  32'(frame_start), 32'h1);
    wait_an(4'hD, dk, cy);
    check("b_seg1", 32'(seg), 32'h30);
    check("b_gap1", 32'(dk), 32'(B));
    wait_an(4'hB, dk, cy);
    check("b_seg2", 32'(seg), 32'h24);
    check("b_gap2", 32'(dk), 32'(B));
    wait_an(4'h7, dk, cy);
    check("b_seg3", 32'(seg), 32'h79);
    check("b_gap3", 32'(dk), 32'(B));

    // Frame-coherent latch: AAAA loaded, then 5555 appears mid-frame
    value = 16'hAAAA;
    wait_an(4'hE, dk, cy);
    check("fc_seg0", 32'(seg), 32'h08);
    wait_an(4'hD, dk, cy);
    value = 16'h5555;
    wait_an(4'hB, dk, cy);
    check("fc_seg2", 32'(seg), 32'h08);
    wait_an(4'h7, dk, cy);
    check("fc_seg3", 32'(seg), 32'h08);
    wait_an(4'hE, dk, cy);
    check("fc_new0", 32'(seg), 32'h12);
    check("fc_fs",   32'(frame_start), 32'h1);

    // Leading-zero blanking
    value = 16'h0005; lzb_en = 1;
    wait_an(4'hD, dk, cy);
    wait_an(4'hE, dk, cy);
    check("lz_seg0", 32'(seg), 32'h12);
    wait_an(4'hD, dk, cy);
    check("lz_seg1", 32'(seg), 32'h7F);
    wait_an(4'hB, dk, cy);
    check("lz_seg2", 32'(seg), 32'h7F);
    wait_an(4'h7, dk, cy);
    check("lz_seg3", 32'(seg), 32'h7F);
    value = 16'h0000; lzb_en = 0; dp_in = 4'b0100;
    wait_an(4'hE, dk, cy);
    check("z_seg0", 32'(seg), 32'h40);
    wait_an(4'hD, dk, cy);
    check("z_seg1", 32'(seg), 32'h40);
    check("z_dp1",  32'(dp),  32'h1);
    wait_an(4'hB, dk, cy);
    check("z_dp2",  32'(dp),  32'h0);

    // Disable while digit 2 shown, then restart
    enable = 0;
    @(negedge clk);
    check("dis_an", 32'(an), 32'hF);
    @(negedge clk);
    enable = 1;
    wait_an(4'hE, dk, cy);
    check("reen_lat", 32'(cy), 32'(B + 1));
    check("reen_fs",  32'(frame_start), 32'h1);

    // clr during SHOW
    wait_an(4'hD, dk, cy);
    clr = 1;
    @(negedge clk);
    check("clr_an",  32'(an),  32'hF);
    check("clr_seg", 32'(seg), 32'h7F);
    check("clr_dp",  32'(dp),  32'h1);
    clr = 0;

    // Randomized traffic
    tick_mode = 2;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 40) == 0)
        value = 16'($urandom >> (4 * $urandom_range(4, 8)));
      if ($urandom_range(0, 60) == 0) dp_in  = 4'($urandom);
      if ($urandom_range(0, 60) == 0) lzb_en = 1'($urandom);
      if (enable && $urandom_range(0, 300) == 0) enable = 0;
      else if (!enable && $urandom_range(0, 10) == 0) enable = 1;
      clr = ($urandom_range(0, 1500) == 0);
    end
    clr = 0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
